// File: rtl/mul_seq_arbiter.sv
// mul_seq_arbiter
//   Sequencer and arbiter in front of one shared repeated-addition multiplier
//   datapath (A register, accumulator P, decrementing B counter, B==0 flag).
//   Grants one requester at a time, steps the datapath through
//   LOAD_A -> LOAD_B -> CALC, and returns the truncated product with a
//   one-cycle done pulse on the granted requester's bit.
//
//   Build option: define MUL_SEQ_ARB_RR_EN for round-robin arbitration.
//   Without it, arbitration is fixed priority (lowest index wins).
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req[N_REQ]        per-requester request level
//   op_a, op_b        packed operands, slice i = [i*WIDTH +: WIDTH]
//   gnt[N_REQ]        registered one-hot grant, held for the whole operation
//   done[N_REQ]       one-cycle one-hot completion pulse
//   result[WIDTH]     product of the last completed operation
//   busy              high while an operation is in flight
//   data_in[WIDTH]    operand bus to the datapath
//   ldA ldB ldP clrP decB   datapath strobes
//   eqz               datapath B==0 flag
//   dp_p[WIDTH]       datapath accumulator value
module mul_seq_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] op_a,
  input  logic [N_REQ*WIDTH-1:0] op_b,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       result,
  output logic                   busy,
  output logic [WIDTH-1:0]       data_in,
  output logic                   ldA,
  output logic                   ldB,
  output logic                   ldP,
  output logic                   clrP,
  output logic                   decB,
  input  logic                   eqz,
  input  logic [WIDTH-1:0]       dp_p
);

  localparam int IW  = $clog2(N_REQ);
  localparam int IW1 = IW + 1;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, CALC, DONE} state_t;

  state_t            state_reg;
  logic [N_REQ-1:0]  gnt_reg;
  logic [N_REQ-1:0]  done_reg;
  logic [WIDTH-1:0]  result_reg;
  logic              busy_reg;
  logic [WIDTH-1:0]  data_in_reg;
  logic              ldA_reg;
  logic              ldB_reg;
  logic              clrP_reg;
  logic [WIDTH-1:0]  b_lat_reg;

  // Unpacked views of the operand buses so the winner can index them directly.
  logic [WIDTH-1:0] a_arr [N_REQ];
  logic [WIDTH-1:0] b_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign a_arr[gi] = op_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = op_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [IW-1:0] win;
  logic          found;

  assign found = |req;

`ifdef MUL_SEQ_ARB_RR_EN
  logic [IW-1:0] ptr_reg;
  logic [IW:0]   idx;
  logic          taken;

  // Search starts at the pointer and wraps; first set request wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    taken = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_reg} + IW1'(k);
      if (idx >= IW1'(N_REQ)) idx = idx - IW1'(N_REQ);
      if (!taken && req[idx[IW-1:0]]) begin
        taken = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest set index in win.
  always_comb begin
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) win = IW'(k);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      gnt_reg     <= '0;
      done_reg    <= '0;
      result_reg  <= '0;
      busy_reg    <= 1'b0;
      data_in_reg <= '0;
      ldA_reg     <= 1'b0;
      ldB_reg     <= 1'b0;
      clrP_reg    <= 1'b0;
      b_lat_reg   <= '0;
`ifdef MUL_SEQ_ARB_RR_EN
      ptr_reg     <= '0;
`endif
    end else begin
      // Strobes and the operand bus are pulses: default them low each cycle.
      done_reg    <= '0;
      data_in_reg <= '0;
      ldA_reg     <= 1'b0;
      ldB_reg     <= 1'b0;
      clrP_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (found) begin
            gnt_reg     <= ONE << win;
            busy_reg    <= 1'b1;
            // A is captured straight into the bus register for LOAD_A;
            // B is held until LOAD_B so operands may change after the grant.
            data_in_reg <= a_arr[win];
            b_lat_reg   <= b_arr[win];
            ldA_reg     <= 1'b1;
            state_reg   <= LOAD_A;
`ifdef MUL_SEQ_ARB_RR_EN
            ptr_reg     <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
`endif
          end
        end
        LOAD_A: begin
          data_in_reg <= b_lat_reg;
          ldB_reg     <= 1'b1;
          clrP_reg    <= 1'b1;
          state_reg   <= LOAD_B;
        end
        LOAD_B: begin
          state_reg <= CALC;
        end
        CALC: begin
          if (eqz) begin
            result_reg <= dp_p;
            done_reg   <= gnt_reg;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          gnt_reg   <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Accumulate only while B is non-zero, so nothing is added once B hits 0.
  assign ldP     = (state_reg == CALC) && !eqz;
  assign decB    = ldP;

  assign gnt     = gnt_reg;
  assign done    = done_reg;
  assign result  = result_reg;
  assign busy    = busy_reg;
  assign data_in = data_in_reg;
  assign ldA     = ldA_reg;
  assign ldB     = ldB_reg;
  assign clrP    = clrP_reg;

endmodule

// File: tb/tb_mul_seq_arbiter.sv
module tb_mul_seq_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic           busy;
  logic [W-1:0]   data_in;
  logic           ldA, ldB, ldP, clrP, decB;
  logic           eqz;
  logic [W-1:0]   dp_p;

  mul_seq_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .done(done), .result(result), .busy(busy),
    .data_in(data_in), .ldA(ldA), .ldB(ldB), .ldP(ldP), .clrP(clrP),
    .decB(decB), .eqz(eqz), .dp_p(dp_p)
  );

  always #5 clk = ~clk;

  // Behavioural model of the shared datapath driven by the strobes.
  logic [W-1:0] dp_a  = '0;
  logic [W-1:0] dp_b  = '0;
  logic [W-1:0] dp_pr = '0;
  always @(posedge clk) begin
    if (ldA) dp_a <= data_in;
    if (ldB) dp_b <= data_in;
    else if (decB) dp_b <= dp_b - 16'd1;
    if (clrP) dp_pr <= '0;
    else if (ldP) dp_pr <= dp_pr + dp_a;
  end
  assign eqz  = (dp_b == 16'd0);
  assign dp_p = dp_pr;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct { int idx; logic [W-1:0] res; } sb_t;
  sb_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer plus per-cycle strobe exclusivity.
  always @(negedge clk) begin
    if (mon_en) begin
      int grp;
      sb_t e;
      grp = int'(ldA) + int'(ldB | clrP) + int'(ldP | decB);
      chk("ldp_while_eqz", {31'd0, ldP & eqz}, 32'd0);
      chk("strobe_groups", {31'd0, grp > 1}, 32'd0);
      if (done !== '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {28'd0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_onehot", {28'd0, done}, 32'd1 << e.idx);
          chk("result", {16'd0, result}, {16'd0, e.res});
          $display("txn: requester %0d done, result=%04h expected=%04h", e.idx, result, e.res);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in an IDLE cycle (cycle 0). Returns in the DONE cycle.
  task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit drive, input bit corrupt);
    int cyc;
    logic [4:0] exp_s;
    logic [W-1:0] exp_d;
    sb_t e;
    if (drive) begin
      op_a[idx*W +: W] = a;
      op_b[idx*W +: W] = b;
      req = N'(1) << idx;
    end
    e.idx = idx;
    e.res = a * b;
    sb.push_back(e);
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (drive && cyc == 1) req = '0;
      if (corrupt && cyc == 2) begin
        op_a[idx*W +: W] = 16'hFFFF;
        op_b[idx*W +: W] = 16'h0FFF;
      end
      // {ldA, ldB, clrP, ldP, decB} expected from the cycle number
      if (cyc == 1)                            begin exp_s = 5'b10000; exp_d = a;  end
      else if (cyc == 2)                       begin exp_s = 5'b01100; exp_d = b;  end
      else if (cyc >= 3 && cyc <= 2 + int'(b)) begin exp_s = 5'b00011; exp_d = '0; end
      else                                     begin exp_s = 5'b00000; exp_d = '0; end
      chk($sformatf("strobes_r%0d_c%0d", idx, cyc), {27'd0, ldA, ldB, clrP, ldP, decB}, {27'd0, exp_s});
      chk($sformatf("data_in_r%0d_c%0d", idx, cyc), {16'd0, data_in}, {16'd0, exp_d});
      if (cyc <= 4 + int'(b)) begin
        chk("gnt", {28'd0, gnt}, 32'd1 << idx);
        chk("busy", {31'd0, busy}, 32'd1);
      end
    end while (done === '0 && cyc < int'(b) + 20);
    chk($sformatf("latency_r%0d", idx), cyc, 32'(int'(b) + 4));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"}, {28'd0, gnt}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {28'd0, done}, 32'd0);
    chk({tag, "_strobes"}, {27'd0, ldA, ldB, clrP, ldP, decB}, 32'd0);
    chk({tag, "_data_in"}, {16'd0, data_in}, 32'd0);
  endtask

  initial begin
    int w;
    rst  = 1'b1;
    req  = '0;
    op_a = '0;
    op_b = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    chk("reset_result", {16'd0, result}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single request, A=7 B=3
    run_op(1, 16'd7, 16'd3, 1'b1, 1'b0);
    tick();
    check_idle_outputs("idle_after_op");

    // B=0 and truncating wrap
    run_op(0, 16'd9, 16'd0, 1'b1, 1'b0);
    tick();
    run_op(2, 16'h8001, 16'd2, 1'b1, 1'b0);
    tick();

    // Operands changed after the grant must not matter
    run_op(2, 16'd5, 16'd4, 1'b1, 1'b1);
    tick();

    // Contention from a fresh reset with every request held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i*W +: W] = 16'(i + 2);
      op_b[i*W +: W] = 16'(i + 1);
    end
    req = '1;
    for (int i = 0; i < 5; i++) begin
`ifdef MUL_SEQ_ARB_RR_EN
      w = i % N;
`else
      w = 0;
`endif
      run_op(w, 16'(w + 2), 16'(w + 1), 1'b0, 1'b0);
      if (i == 4) req = '0;
      tick();
      chk("contention_idle_busy", {31'd0, busy}, 32'd0);
    end

    // Reset in the middle of CALC: no done for the aborted request
    op_a[3*W +: W] = 16'd3;
    op_b[3*W +: W] = 16'd10;
    req = 4'b1000;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) req = '0;
    end
    chk("midcalc_ldP_before_reset", {31'd0, ldP}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("after_midcalc_reset");
    repeat (15) tick();
    chk("no_done_after_abort_queue", sb.size(), 32'd0);

    // Fresh request after the abort
    run_op(2, 16'd11, 16'd5, 1'b1, 1'b0);
    tick();
    tick();
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_arbiter.md
# mul_seq_arbiter

Sequencer and arbiter for the shared 16-bit repeated-addition multiplier datapath (A register, accumulator P, decrementing B counter, zero comparator). It accepts multiply requests from up to N_REQ requesters, grants one at a time, drives the datapath load, clear and decrement strobes through a fixed load/compute sequence, and returns the truncated product with a per-requester done pulse. It replaces the single-user start/done controller wherever more than one client shares one datapath instance.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- WIDTH, 16: operand and result width; must match the datapath.
- clk  in  1  single clock; all logic updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level.
- op_a  in  N_REQ*WIDTH  multiplicand per requester; slice i = [i*WIDTH +: WIDTH].
- op_b  in  N_REQ*WIDTH  multiplier (iteration count) per requester, same slicing.
- gnt  out  N_REQ  one-hot grant, registered.
- done  out  N_REQ  one-cycle one-hot completion pulse.
- result  out  WIDTH  product of the last completed operation, registered.
- busy  out  1  high while an operation is in flight.
- data_in  out  WIDTH  datapath operand bus.
- ldA, ldB, ldP, clrP, decB  out  1 each  datapath strobes.
- eqz  in  1  datapath B==0 flag.
- dp_p  in  WIDTH  datapath accumulator P output.

## Operation
- States: IDLE, LOAD_A, LOAD_B, CALC, DONE.
- IDLE: all strobes 0, busy 0. If any req bit is set, pick winner g, register gnt = 1<<g, latch op_a[g] and op_b[g] into internal operand registers, go to LOAD_A. Operands need only be valid in the cycle the grant is taken.
- LOAD_A: data_in = latched A, ldA = 1 → LOAD_B.
- LOAD_B: data_in = latched B, ldB = 1, clrP = 1 → CALC.
- CALC: if eqz = 0, assert ldP = 1 and decB = 1, stay. If eqz = 1, assert no strobes, capture dp_p into result, go to DONE. ldP is gated by ~eqz so no extra accumulation occurs after B reaches 0.
- DONE: done[g] = 1 for one cycle, result is valid, then gnt clears → IDLE.
- data_in = 0 in all states other than LOAD_A/LOAD_B.
- At most one strobe group is active per state; ldA/ldB/clrP never overlap ldP/decB.
- Arithmetic: product = (A*B) mod 2^WIDTH (datapath truncation). B = 0 gives result 0; A = 0 gives 0 after B iterations.
- A requester dropping req mid-operation does not abort; the operation completes and done still pulses.
- A requester holding req after its done is treated as a new request and is re-arbitrated in IDLE.

## Timing
- Reset values: state IDLE, gnt 0, done 0, result 0, busy 0, all strobes 0, data_in 0, RR pointer 0. Datapath registers are not reset; every operation reloads them.
- Reset mid-operation returns to IDLE on the next edge; no done pulse is issued for the aborted request.
- Cycle numbering: cycle 0 is the IDLE cycle in which req is sampled. LOAD_A is cycle 1, LOAD_B is cycle 2, CALC covers cycles 3..3+B, and DONE is cycle 4+B.
- Request-to-done latency is B+4 cycles. Back-to-back occupancy is B+5 cycles per operation, since IDLE is always visited once between operations.
- busy and gnt are high from cycle 1 through cycle 4+B.
- Simultaneous requests: exactly one grant; the others wait in IDLE with req held.

## Configuration
- MUL_SEQ_ARB_RR_EN defined: round-robin. The search starts at the pointer; the pointer becomes g+1 (mod N_REQ) when a grant is taken.
- MUL_SEQ_ARB_RR_EN undefined: fixed priority, lowest index wins, and the pointer logic is removed.

## Test plan
- Single request: req[1] with A = 7, B = 3 → ldA at cycle 1, ldB+clrP at cycle 2, ldP+decB for 3 cycles, done[1] at cycle 7, result = 21.
- Zero and wrap: B = 0 → done at cycle 4, result = 0. A = 16'h8001, B = 2 → result = 16'h0002.
- Contention with MUL_SEQ_ARB_RR_EN and req = 4'b1111 held: grants are 0,1,2,3,0 in order, each done one-hot matching its grant. Without the macro, the same stimulus grants index 0 every time.
- Operand capture: change op_a/op_b of the granted requester in cycle 2 → result still uses the values sampled in cycle 0.
- Reset mid-CALC with B = 10: assert rst at cycle 6 → next cycle gnt = 0, busy = 0, strobes = 0, no done. A fresh request afterwards completes correctly.
- Strobe exclusivity check on every cycle: ldP is never 1 while eqz = 1, and at most one of {ldA, ldB|clrP, ldP|decB} is active.
